// File: rtl/hello_msg_checker.sv
// ---------------------------------------------------------------------------
// hello_msg_checker
//
// Receive-side checker for the "Hello, World!" banner byte stream. Bytes are
// consumed over a valid/ready handshake. Each message must be the 13 bytes
// "Hello, World!" followed by TERM_BYTE. Every complete, correct message
// produces a one-cycle msg_ok pulse. Every detected mismatch produces a
// one-cycle msg_err pulse. Both outcomes are tallied in saturating counters.
//
// Parameters
//   CNT_W      width of msg_count / err_count
//   TERM_BYTE  terminator expected after the 13th message byte
//
// Ports
//   clk        single clock, all logic on posedge
//   rst        synchronous, active-high reset
//   rx_data    byte from the upstream source
//   rx_valid   rx_data is valid
//   rx_ready   checker can accept; a byte is consumed on rx_valid & rx_ready
//   msg_ok     1-cycle pulse: full message plus terminator matched
//   msg_err    1-cycle pulse: mismatch detected
//   busy       high while inside a message (MATCH, TERM or SKIP)
//   msg_count  saturating count of msg_ok pulses
//   err_count  saturating count of msg_err pulses
//
// Build option
//   HELLO_MSG_CHECKER_RESYNC_EN
//     When defined, a mismatch inside a message (MATCH or TERM) still pulses
//     msg_err, but the offending byte is reused: 'H' starts a new message
//     and TERM_BYTE returns straight to IDLE. Any other byte goes to SKIP.
//     When undefined, every such mismatch goes to SKIP.
// ---------------------------------------------------------------------------
module hello_msg_checker #(
   parameter int unsigned CNT_W     = 16,
   parameter logic [7:0]  TERM_BYTE = 8'h0A
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [7:0]       rx_data,
   input  logic             rx_valid,
   output logic             rx_ready,
   output logic             msg_ok,
   output logic             msg_err,
   output logic             busy,
   output logic [CNT_W-1:0] msg_count,
   output logic [CNT_W-1:0] err_count
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_MATCH,
      ST_TERM,
      ST_DONE,
      ST_SKIP
   } state_t;

   localparam logic [7:0]       FIRST_BYTE = 8'h48;
   localparam logic [3:0]       LAST_IDX   = 4'd12;
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX    = '1;

   // Expected banner, indexed by the position of the byte within the message.
   function automatic logic [7:0] rom_byte(input logic [3:0] pos);
      logic [7:0] b;
      case (pos)
         4'd0:    b = 8'h48;
         4'd1:    b = 8'h65;
         4'd2:    b = 8'h6C;
         4'd3:    b = 8'h6C;
         4'd4:    b = 8'h6F;
         4'd5:    b = 8'h2C;
         4'd6:    b = 8'h20;
         4'd7:    b = 8'h57;
         4'd8:    b = 8'h6F;
         4'd9:    b = 8'h72;
         4'd10:   b = 8'h6C;
         4'd11:   b = 8'h64;
         4'd12:   b = 8'h21;
         default: b = 8'h00;
      endcase
      return b;
   endfunction

   state_t     state;
   state_t     state_nxt;
   logic [3:0] idx;
   logic [3:0] idx_nxt;
   logic       ok_nxt;
   logic       err_nxt;
   logic       beat;
   state_t     resync_state;
   logic [3:0] resync_idx;

   assign beat = rx_valid & rx_ready;

   // Where to go after a mismatch inside a message. With resync enabled the
   // offending byte itself is interpreted as the start of the next frame, so
   // a truncated message followed immediately by a fresh one is not lost.
`ifdef HELLO_MSG_CHECKER_RESYNC_EN
   always_comb begin
      resync_state = ST_SKIP;
      resync_idx   = 4'd0;
      if (rx_data == FIRST_BYTE) begin
         resync_state = ST_MATCH;
         resync_idx   = 4'd1;
      end else if (rx_data == TERM_BYTE) begin
         resync_state = ST_IDLE;
      end
   end
`else
   always_comb begin
      resync_state = ST_SKIP;
      resync_idx   = 4'd0;
   end
`endif

   // Next-state decode. Decisions are taken only on an accepted beat; the
   // single exception is DONE, which is a fixed one-cycle bubble during which
   // rx_ready is low and no beat can be accepted.
   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      ok_nxt    = 1'b0;
      err_nxt   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (beat) begin
               if (rx_data == FIRST_BYTE) begin
                  state_nxt = ST_MATCH;
                  idx_nxt   = 4'd1;
               end else if (rx_data != TERM_BYTE) begin
                  err_nxt   = 1'b1;
                  state_nxt = ST_SKIP;
                  idx_nxt   = 4'd0;
               end
            end
         end
         ST_MATCH: begin
            if (beat) begin
               if (rx_data == rom_byte(idx)) begin
                  if (idx == LAST_IDX) begin
                     state_nxt = ST_TERM;
                     idx_nxt   = 4'd0;
                  end else begin
                     idx_nxt   = idx + 4'd1;
                  end
               end else begin
                  err_nxt   = 1'b1;
                  state_nxt = resync_state;
                  idx_nxt   = resync_idx;
               end
            end
         end
         ST_TERM: begin
            if (beat) begin
               if (rx_data == TERM_BYTE) begin
                  ok_nxt    = 1'b1;
                  state_nxt = ST_DONE;
                  idx_nxt   = 4'd0;
               end else begin
                  err_nxt   = 1'b1;
                  state_nxt = resync_state;
                  idx_nxt   = resync_idx;
               end
            end
         end
         ST_DONE: begin
            state_nxt = ST_IDLE;
            idx_nxt   = 4'd0;
         end
         ST_SKIP: begin
            if (beat && (rx_data == TERM_BYTE)) begin
               state_nxt = ST_IDLE;
               idx_nxt   = 4'd0;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
            idx_nxt   = 4'd0;
         end
      endcase
   end

   // State register plus all registered outputs. rx_ready and busy are
   // derived from the next state so they line up with the state they
   // describe; the pulses and counters move together in the cycle after the
   // deciding beat, and counters hold at all-ones instead of wrapping.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         idx       <= 4'd0;
         rx_ready  <= 1'b0;
         busy      <= 1'b0;
         msg_ok    <= 1'b0;
         msg_err   <= 1'b0;
         msg_count <= '0;
         err_count <= '0;
      end else begin
         state    <= state_nxt;
         idx      <= idx_nxt;
         rx_ready <= (state_nxt != ST_DONE);
         busy     <= (state_nxt == ST_MATCH) || (state_nxt == ST_TERM) ||
                     (state_nxt == ST_SKIP);
         msg_ok   <= ok_nxt;
         msg_err  <= err_nxt;
         if (ok_nxt && (msg_count != CNT_MAX)) begin
            msg_count <= msg_count + CNT_ONE;
         end
         if (err_nxt && (err_count != CNT_MAX)) begin
            err_count <= err_count + CNT_ONE;
         end
      end
   end

endmodule

// File: tb/tb_hello_msg_checker.sv
// ---------------------------------------------------------------------------
// tb_hello_msg_checker
//
// Drives directed banner traffic into two checkers sharing the same inputs:
// the default-width instance and a CNT_W=2 instance used to observe counter
// saturation. Every stimulus line that should produce a pulse first queues
// the hand-computed expected outcome; a monitor pops one entry per pulse
// seen on the main instance and compares pulse kind, counters and rx_ready.
// ---------------------------------------------------------------------------
module tb_hello_msg_checker;

   logic        clk;
   logic        rst;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_ready;
   logic        msg_ok;
   logic        msg_err;
   logic        busy;
   logic [15:0] msg_count;
   logic [15:0] err_count;

   logic        sat_rx_ready;
   logic        sat_msg_ok;
   logic        sat_msg_err;
   logic        sat_busy;
   logic [1:0]  sat_msg_count;
   logic [1:0]  sat_err_count;

   typedef struct {
      bit ok;
      int mc;
      int ec;
      int smc;
      bit rdy;
   } exp_t;

   exp_t sb[$];
   int   checks   = 0;
   int   failures = 0;

   hello_msg_checker #(.CNT_W(16), .TERM_BYTE(8'h0A)) dut (
      .clk       (clk),
      .rst       (rst),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .rx_ready  (rx_ready),
      .msg_ok    (msg_ok),
      .msg_err   (msg_err),
      .busy      (busy),
      .msg_count (msg_count),
      .err_count (err_count)
   );

   hello_msg_checker #(.CNT_W(2), .TERM_BYTE(8'h0A)) dut_sat (
      .clk       (clk),
      .rst       (rst),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .rx_ready  (sat_rx_ready),
      .msg_ok    (sat_msg_ok),
      .msg_err   (sat_msg_err),
      .busy      (sat_busy),
      .msg_count (sat_msg_count),
      .err_count (sat_err_count)
   );

   // Free-running clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Single comparison point; every check in the bench funnels through here
   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         failures++;
         $display("[TB] FAIL %s actual=%0d expected=%0d (t=%0t)", name, actual, expected, $time);
      end
   endtask

   // Queue the outcome the next pulse must show
   task automatic expectPulse(input bit ok, input int mc, input int ec, input int smc);
      exp_t e;
      e.ok  = ok;
      e.mc  = mc;
      e.ec  = ec;
      e.smc = smc;
      e.rdy = !ok;
      sb.push_back(e);
   endtask

   // Present one byte and hold it until the checker accepts it
   task automatic sendByte(input logic [7:0] b);
      bit acc;
      int waits;
      rx_data  = b;
      rx_valid = 1'b1;
      waits    = 0;
      do begin
         acc = rx_ready;
         @(posedge clk);
         #1;
         waits++;
      end while (!acc && waits < 20);
      if (!acc) checkOutput("accept_timeout", int'(rx_ready), 1);
   endtask

   // Send a string; with gap set, each beat is followed by an idle cycle
   // during which the byte stays on rx_data with rx_valid low
   task automatic applyStimulus(input string s, input bit gap);
      for (int i = 0; i < s.len(); i++) begin
         sendByte(s[i]);
         if (gap) begin
            rx_valid = 1'b0;
            @(posedge clk);
            #1;
         end
      end
      rx_valid = 1'b0;
   endtask

   task automatic doReset();
      rx_valid = 1'b0;
      rst      = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;
   endtask

   // Wait for every queued outcome to be observed, then idle a little so a
   // stray extra pulse would still reach the monitor
   task automatic waitDrain(input string name);
      for (int i = 0; i < 30 && sb.size() != 0; i++) begin
         @(posedge clk);
         #1;
      end
      if (sb.size() != 0) begin
         checkOutput({name, "_missing_pulse"}, 0, sb.size());
         sb.delete();
      end
      repeat (4) @(posedge clk);
      #1;
   endtask

   // Monitor: one scoreboard entry per observed pulse
   always @(negedge clk) begin
      if (msg_ok || msg_err) begin
         exp_t e;
         checkOutput("ok_err_exclusive", int'(msg_ok & msg_err), 0);
         if (sb.size() == 0) begin
            checkOutput("unexpected_pulse_ok", int'(msg_ok), 0);
         end else begin
            e = sb.pop_front();
            checkOutput("pulse_is_ok", int'(msg_ok), int'(e.ok));
            checkOutput("pulse_is_err", int'(msg_err), int'(!e.ok));
            checkOutput("msg_count", int'(msg_count), e.mc);
            checkOutput("err_count", int'(err_count), e.ec);
            checkOutput("sat_msg_count", int'(sat_msg_count), e.smc);
            checkOutput("rx_ready_at_pulse", int'(rx_ready), int'(e.rdy));
         end
      end
   end

   // Absolute time limit
   initial begin
      #500000;
      $display("[TB] FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst      = 1'b1;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      $display("[TB] reset state");
      checkOutput("reset_rx_ready", int'(rx_ready), 0);
      checkOutput("reset_busy", int'(busy), 0);
      checkOutput("reset_msg_ok", int'(msg_ok), 0);
      checkOutput("reset_msg_err", int'(msg_err), 0);
      checkOutput("reset_msg_count", int'(msg_count), 0);
      checkOutput("reset_err_count", int'(err_count), 0);
      rst = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("ready_after_reset", int'(rx_ready), 1);

      // Lone terminator in IDLE is swallowed, then one clean message
      $display("[TB] good message, valid held high");
      applyStimulus("\n", 0);
      checkOutput("idle_term_busy", int'(busy), 0);
      expectPulse(1'b1, 1, 0, 1);
      applyStimulus("H", 0);
      checkOutput("busy_after_H", int'(busy), 1);
      applyStimulus("ello, World!\n", 0);
      checkOutput("ready_low_after_term", int'(rx_ready), 0);
      waitDrain("good");
      checkOutput("ready_back_high", int'(rx_ready), 1);
      checkOutput("idle_busy", int'(busy), 0);
      checkOutput("good_msg_count", int'(msg_count), 1);
      checkOutput("good_err_count", int'(err_count), 0);

      // Mismatch, skip (including an 'H' inside SKIP), recovery, case and
      // terminator errors
      $display("[TB] mismatch and skip");
      doReset();
      expectPulse(1'b0, 0, 1, 0);
      applyStimulus("HellxHello\n", 0);
      expectPulse(1'b1, 1, 1, 1);
      applyStimulus("Hello, World!\n", 0);
      expectPulse(1'b0, 1, 2, 1);
      applyStimulus("hello\n", 0);
      expectPulse(1'b0, 1, 3, 1);
      applyStimulus("Hello, World!x\n", 0);
      expectPulse(1'b1, 2, 3, 2);
      applyStimulus("\nHello, World!\n", 0);
      waitDrain("mismatch");
      checkOutput("mismatch_err_count", int'(err_count), 3);

      // Restarted message in the middle of a frame
      $display("[TB] restart inside message");
      doReset();
      expectPulse(1'b0, 0, 1, 0);
`ifdef HELLO_MSG_CHECKER_RESYNC_EN
      expectPulse(1'b1, 1, 1, 1);
`endif
      applyStimulus("HeH", 0);
      applyStimulus("ello, World!\n", 0);
      waitDrain("restart");
`ifdef HELLO_MSG_CHECKER_RESYNC_EN
      checkOutput("restart_msg_count", int'(msg_count), 1);
`else
      checkOutput("restart_msg_count", int'(msg_count), 0);
`endif

      // Valid toggling with stalled data in the idle cycles
      $display("[TB] valid toggling");
      doReset();
      expectPulse(1'b1, 1, 0, 1);
      applyStimulus("Hello, World!\n", 1);
      waitDrain("toggle");
      checkOutput("toggle_err_count", int'(err_count), 0);

      // Reset mid-message drops progress silently
      $display("[TB] reset mid-message");
      doReset();
      applyStimulus("Hello,", 0);
      checkOutput("partial_busy", int'(busy), 1);
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("midrst_msg_count", int'(msg_count), 0);
      checkOutput("midrst_err_count", int'(err_count), 0);
      checkOutput("midrst_busy", int'(busy), 0);
      checkOutput("midrst_rx_ready", int'(rx_ready), 0);
      rst = 1'b0;
      @(posedge clk);
      #1;
      expectPulse(1'b1, 1, 0, 1);
      applyStimulus("Hello, World!\n", 0);
      waitDrain("midrst");

      // Back-to-back messages; the narrow instance saturates at 3
      $display("[TB] counter saturation");
      doReset();
      expectPulse(1'b1, 1, 0, 1);
      expectPulse(1'b1, 2, 0, 2);
      expectPulse(1'b1, 3, 0, 3);
      expectPulse(1'b1, 4, 0, 3);
      expectPulse(1'b1, 5, 0, 3);
      for (int m = 0; m < 5; m++) begin
         applyStimulus("Hello, World!\n", 0);
      end
      waitDrain("sat");
      checkOutput("sat_final_count", int'(sat_msg_count), 3);
      checkOutput("wide_final_count", int'(msg_count), 5);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
